// File: rtl/gcd_host_pkg.sv
// rtl/gcd_host_pkg.sv - shared constants and types for the GCD host driver
//
// Purpose : default widths and the tag-queue entry layout used by gcd_host
//           and gcd_host_tagq.
// Contents: DATA_W_DEF, TAG_W_DEF, MAX_OUT_DEF, tag_entry_t {a, b, tag}.
package gcd_host_pkg;

  localparam int DATA_W_DEF  = 4;
  localparam int TAG_W_DEF   = 4;
  localparam int MAX_OUT_DEF = 4;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [TAG_W_DEF-1:0]  tag;
  } tag_entry_t;

endpackage

// File: rtl/gcd_host_tagq.sv
// rtl/gcd_host_tagq.sv - in-flight request queue (first-word fall-through FIFO)
//
// Purpose : holds the operands and tag of every issued request until its
//           result is collected.
// Ports   : clk_i, rst_i (async, active-high)
//           push, din   - write an entry (ignored when full)
//           pop         - drop the head entry (ignored when empty)
//           head        - oldest entry, valid while !empty
//           full, empty, count
module gcd_host_tagq
  import gcd_host_pkg::*;
#(
  parameter int  DEPTH   = MAX_OUT_DEF,
  parameter type entry_t = tag_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  entry_t                     din,
  input  logic                       pop,
  output entry_t                     head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: contents are only observed through count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/gcd_host.sv
// rtl/gcd_host.sv - initiator-side driver for the GCD interface wrapper
//
// Purpose : takes operand pairs from the cmd stream, writes them to the
//           wrapper A/B ports, pops results from Y and returns them in order
//           with the original operands and a wrapping sequence tag.
// Ports   : clk_i, rst_i (async, active-high)
//           cmd_valid/cmd_ready/cmd_a/cmd_b        - upstream commands
//           a_data/a_en/a_rdy, b_data/b_en/b_rdy   - wrapper operand ports
//           y_data/y_en/y_rdy                      - wrapper result port (FWFT)
//           res_valid/res_ready/res_data/res_a/res_b/res_tag - downstream results
//           out_cnt - requests in flight, err_o - sticky unsolicited-result flag
// Options : GCD_HOST_CHECK_EN adds chk_err_o/chk_cnt_o result sanity checking.
module gcd_host
  import gcd_host_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [DATA_W-1:0]            cmd_a,
  input  logic [DATA_W-1:0]            cmd_b,
  output logic [DATA_W-1:0]            a_data,
  output logic                         a_en,
  input  logic                         a_rdy,
  output logic [DATA_W-1:0]            b_data,
  output logic                         b_en,
  input  logic                         b_rdy,
  input  logic [DATA_W-1:0]            y_data,
  output logic                         y_en,
  input  logic                         y_rdy,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [DATA_W-1:0]            res_data,
  output logic [DATA_W-1:0]            res_a,
  output logic [DATA_W-1:0]            res_b,
  output logic [TAG_W-1:0]             res_tag,
  output logic [$clog2(MAX_OUT+1)-1:0] out_cnt,
`ifdef GCD_HOST_CHECK_EN
  output logic                         chk_err_o,
  output logic [7:0]                   chk_cnt_o,
`endif
  output logic                         err_o
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  logic [TAG_W-1:0] tag_q;
  entry_t           push_entry;
  entry_t           head;
  logic             q_full;
  logic             q_empty;
  logic             issue;
  logic             capture;

  // !a_en gives the wrapper one cycle to update its rdy flags after a write.
  assign cmd_ready  = !rst_i && a_rdy && b_rdy && !a_en && !q_full;
  assign issue      = cmd_valid && cmd_ready;
  assign push_entry = '{a: cmd_a, b: cmd_b, tag: tag_q};

  // Pop only when the result register is free or being drained this cycle.
  assign y_en    = !rst_i && y_rdy && (!res_valid || res_ready);
  assign capture = y_en && !q_empty;

  gcd_host_tagq #(
    .DEPTH   (MAX_OUT),
    .entry_t (entry_t)
  ) u_tagq (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (issue),
    .din   (push_entry),
    .pop   (capture),
    .head  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (out_cnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_en      <= 1'b0;
      b_en      <= 1'b0;
      a_data    <= '0;
      b_data    <= '0;
      tag_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_a     <= '0;
      res_b     <= '0;
      res_tag   <= '0;
      err_o     <= 1'b0;
    end else begin
      a_en <= issue;
      b_en <= issue;
      if (issue) begin
        a_data <= cmd_a;
        b_data <= cmd_b;
        tag_q  <= tag_q + TAG_W'(1);
      end
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= y_data;
        res_a     <= head.a;
        res_b     <= head.b;
        res_tag   <= head.tag;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      // A result popped with nothing outstanding is a wrapper protocol error.
      if (y_en && q_empty) err_o <= 1'b1;
    end
  end

`ifdef GCD_HOST_CHECK_EN
  logic chk_bad;

  // gcd(x,0)=x, so a zero operand is divisible by any nonzero result;
  // a zero result is only legal for gcd(0,0).
  always_comb begin
    chk_bad = 1'b0;
    if (y_data == '0) chk_bad = (head.a != '0) || (head.b != '0);
    else              chk_bad = ((head.a % y_data) != '0) || ((head.b % y_data) != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chk_err_o <= 1'b0;
      chk_cnt_o <= '0;
    end else if (capture && chk_bad) begin
      chk_err_o <= 1'b1;
      if (chk_cnt_o != 8'hff) chk_cnt_o <= chk_cnt_o + 8'd1;
    end
  end
`endif

endmodule
